// File: rtl/store_buffer_if.sv
// Data-memory port of the store buffer: the write channel drained from the buffer head,
// plus the combinational read channel used by MEM-stage loads.
interface store_buffer_if #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
);
  logic                 mem_we;
  logic [addWidth-1:0]  mem_addr;
  logic [dataWidth-1:0] mem_wdata;
  logic                 mem_wready;
  logic [addWidth-1:0]  mem_raddr;
  logic [dataWidth-1:0] mem_rdata;

  modport master (
    output mem_we, mem_addr, mem_wdata, mem_raddr,
    input  mem_wready, mem_rdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, mem_raddr,
    output mem_wready, mem_rdata
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: a circular FIFO of pending stores
// that drains one per accepted write and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWriteM,
  input  logic                       MemReadM,
  input  logic [addWidth-1:0]        ALUOutM,
  input  logic [dataWidth-1:0]       WriteDataM,
  output logic [dataWidth-1:0]       ReadDataM,
  output logic                       StallM,
  output logic                       Empty,
  output logic [$clog2(DEPTH):0]     Count,
  store_buffer_if.master             mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [addWidth-1:0]  addr;
    logic [dataWidth-1:0] data;
  } entry_t;

  entry_t          buf_q [DEPTH];
  logic [PW-1:0]   hd_q, hd_d;
  logic [PW-1:0]   tl_q, tl_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   fwd_idx;
  logic            full;
  logic            push;
  logic            pop;

  assign full   = (count_q == CW'(DEPTH));
  assign Empty  = (count_q == '0);
  assign Count  = count_q;

  // Stall looks only at local state, keeping mem_wready out of the hazard-unit path.
  assign StallM = MemWriteM & full;
  assign push   = MemWriteM & ~full;
  assign pop    = mem.mem_we & mem.mem_wready;

  assign mem.mem_we    = ~Empty;
  assign mem.mem_addr  = buf_q[hd_q].addr;
  assign mem.mem_wdata = buf_q[hd_q].data;
  assign mem.mem_raddr = ALUOutM;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hd_d    = hd_q;
    tl_d    = tl_q;
    count_d = count_q;
    if (push) tl_d = tl_q + PW'(1);
    if (pop)  hd_d = hd_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Walk oldest to youngest so the last hit wins; the head stays valid while it pops.
  always_comb begin
    ReadDataM = mem.mem_rdata;
    fwd_idx   = hd_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = hd_q + PW'(i);
      if (MemReadM && (CW'(i) < count_q) && (buf_q[fwd_idx].addr == ALUOutM))
        ReadDataM = buf_q[fwd_idx].data;
    end
  end

  // NOTE: entry storage has no reset; Count alone defines validity, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) buf_q[tl_q] <= '{addr: ALUOutM, data: WriteDataM};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hd_q    <= '0;
      tl_q    <= '0;
      count_q <= '0;
    end else begin
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      count_q <= count_d;
    end
  end

endmodule
